// File: rtl/pipe_skid_reg_pkg.sv
// rtl/pipe_skid_reg_pkg.sv - shared state encodings and constants for the pipeline skid register
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    PSR_EMPTY = 2'd0,
    PSR_ONE   = 2'd1,
    PSR_FULL  = 2'd2
  } psr_state_e;

  localparam int unsigned PSR_DEF_PC_W   = 30;
  localparam int unsigned PSR_DEF_DATA_W = 128;
  localparam int unsigned PSR_DEF_CNT_W  = 16;

  localparam logic [PSR_DEF_DATA_W-1:0] PSR_NOP_PAYLOAD = '0;

  // Level of the reset input that means "in reset".
  localparam logic PSR_RESET_ACTIVE = 1'b0;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - valid/ready stage handshake carrying a PC and an opaque payload
interface pipe_skid_reg_if #(
  parameter int unsigned PC_W   = 30,
  parameter int unsigned DATA_W = 128
);

  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output pc,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  pc,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// rtl/pipe_skid_reg_sat_counter.sv - saturating up-counter for performance monitoring
module sat_counter
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset == PSR_RESET_ACTIVE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - generic pipeline stage register with 2-entry skid buffer, flush and bubble counter
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned       PC_W        = PSR_DEF_PC_W,
  parameter int unsigned       DATA_W      = PSR_DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W       = PSR_DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  pipe_skid_reg_if.slave        up,
  pipe_skid_reg_if.master       dn,
  output logic                  skid_full,
  output logic [CNT_W-1:0]      bubble_cnt
);

  psr_state_e        state_q, state_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic up_ready;
  logic dn_valid;
  logic up_fire;
  logic dn_fire;

  // Both handshake outputs decode straight from the state flop, so up_ready is registered.
  assign up_ready = (state_q != PSR_FULL);
  assign dn_valid = (state_q != PSR_EMPTY);
  assign up_fire  = up.valid & up_ready & ~flush;
  assign dn_fire  = dn_valid & dn.ready & ~stall;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d     = PSR_EMPTY;
      main_pc_d   = '0;
      main_data_d = NOP_PAYLOAD;
      skid_pc_d   = '0;
      skid_data_d = NOP_PAYLOAD;
    end else begin
      unique case (state_q)
        PSR_EMPTY: begin
          if (up_fire) begin
            state_d     = PSR_ONE;
            main_pc_d   = up.pc;
            main_data_d = up.data;
          end
        end
        PSR_ONE: begin
          if (up_fire && dn_fire) begin
            main_pc_d   = up.pc;
            main_data_d = up.data;
          end else if (up_fire) begin
            state_d     = PSR_FULL;
            skid_pc_d   = up.pc;
            skid_data_d = up.data;
          end else if (dn_fire) begin
            state_d     = PSR_EMPTY;
            main_pc_d   = '0;
            main_data_d = NOP_PAYLOAD;
          end
        end
        PSR_FULL: begin
          if (dn_fire) begin
            state_d     = PSR_ONE;
            main_pc_d   = skid_pc_q;
            main_data_d = skid_data_q;
            skid_pc_d   = '0;
            skid_data_d = NOP_PAYLOAD;
          end
        end
        default: begin
          state_d     = PSR_EMPTY;
          main_pc_d   = '0;
          main_data_d = NOP_PAYLOAD;
          skid_pc_d   = '0;
          skid_data_d = NOP_PAYLOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset == PSR_RESET_ACTIVE) begin
      state_q     <= PSR_EMPTY;
      main_pc_q   <= '0;
      main_data_q <= NOP_PAYLOAD;
      skid_pc_q   <= '0;
      skid_data_q <= NOP_PAYLOAD;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign up.ready  = up_ready;
  assign dn.valid  = dn_valid;
  assign dn.pc     = main_pc_q;
  assign dn.data   = main_data_q;
  assign skid_full = ~up_ready;

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~dn_valid),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;

  localparam int unsigned PC_W   = 30;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             flush;
  logic             skid_full;
  logic [CNT_W-1:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  pipe_skid_reg_if #(.PC_W(PC_W), .DATA_W(DATA_W)) up_if ();
  pipe_skid_reg_if #(.PC_W(PC_W), .DATA_W(DATA_W)) dn_if ();

  pipe_skid_reg #(
    .PC_W        (PC_W),
    .DATA_W      (DATA_W),
    .NOP_PAYLOAD ({DATA_W{1'b0}}),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .up         (up_if),
    .dn         (dn_if),
    .skid_full  (skid_full),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] data_of(input logic [PC_W-1:0] p);
    return {4{2'b10, p}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [PC_W-1:0] p);
    up_if.valid = v;
    up_if.pc    = p;
    up_if.data  = data_of(p);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    dn_if.ready = 1'b0;
    offer(1'b1, 30'h10);
    #1;
    tick();
    tick();
    chk("rst_dn_valid", dn_if.valid, 0);
    chk("rst_dn_pc", dn_if.pc, 0);
    chk("rst_dn_data", dn_if.data, 0);
    chk("rst_up_ready", up_if.ready, 1);
    chk("rst_skid_full", skid_full, 0);
    chk("rst_bubble", bubble_cnt, 0);

    reset = 1'b1;
    offer(1'b0, 30'h0);
    tick();
    chk("bubble_1", bubble_cnt, 1);
    tick();
    chk("bubble_2", bubble_cnt, 2);

    // streaming: each offered PC appears one cycle later
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, PC_W'(i));
      tick();
      chk("stream_valid", dn_if.valid, 1);
      chk("stream_pc", dn_if.pc, 128'(i));
      chk("stream_data", dn_if.data, data_of(PC_W'(i)));
      chk("stream_skid", skid_full, 0);
    end
    offer(1'b0, 30'h0);
    tick();
    chk("stream_drain_valid", dn_if.valid, 0);
    chk("stream_drain_pc", dn_if.pc, 0);
    chk("stream_bubble", bubble_cnt, 3);

    // skid fill with back-pressure
    dn_if.ready = 1'b0;
    offer(1'b1, 30'd5);
    tick();
    chk("skid_main5", dn_if.pc, 5);
    offer(1'b1, 30'd6);
    tick();
    chk("skid_full_set", skid_full, 1);
    chk("skid_up_ready", up_if.ready, 0);
    offer(1'b1, 30'd7);
    tick();
    chk("skid_hold_pc", dn_if.pc, 5);
    chk("skid_hold_full", skid_full, 1);
    dn_if.ready = 1'b1;
    tick();
    chk("skid_out6", dn_if.pc, 6);
    chk("skid_out6_data", dn_if.data, data_of(30'd6));
    chk("skid_up_ready_back", up_if.ready, 1);
    tick();
    chk("skid_out7", dn_if.pc, 7);
    chk("skid_out7_valid", dn_if.valid, 1);
    offer(1'b0, 30'h0);
    tick();
    chk("skid_empty", dn_if.valid, 0);
    chk("skid_bubble", bubble_cnt, 4);

    // stall holds a full stage even with dn_ready high
    dn_if.ready = 1'b0;
    offer(1'b1, 30'd5);
    tick();
    offer(1'b1, 30'd6);
    tick();
    offer(1'b0, 30'h0);
    stall = 1'b1;
    dn_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pc", dn_if.pc, 5);
      chk("stall_hold_full", skid_full, 1);
    end
    stall = 1'b0;
    tick();
    chk("stall_rel_pc6", dn_if.pc, 6);
    chk("stall_rel_skid", skid_full, 0);
    tick();
    chk("stall_rel_empty", dn_if.valid, 0);
    chk("stall_bubble", bubble_cnt, 5);

    // flush wins over stall and drops the same-cycle entry
    dn_if.ready = 1'b0;
    offer(1'b1, 30'd5);
    tick();
    offer(1'b1, 30'd6);
    tick();
    chk("flush_pre_full", skid_full, 1);
    stall = 1'b1;
    flush = 1'b1;
    dn_if.ready = 1'b1;
    offer(1'b1, 30'd9);
    tick();
    chk("flush_valid", dn_if.valid, 0);
    chk("flush_pc", dn_if.pc, 0);
    chk("flush_data", dn_if.data, 0);
    chk("flush_up_ready", up_if.ready, 1);
    chk("flush_skid", skid_full, 0);
    chk("flush_bubble", bubble_cnt, 6);
    flush = 1'b0;
    stall = 1'b0;
    offer(1'b0, 30'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no9_valid", dn_if.valid, 0);
      chk("flush_no9_pc", dn_if.pc, 0);
    end

    // counter saturation then reset mid-run from a full stage
    for (int i = 0; i < 20; i++) tick();
    chk("sat_max", bubble_cnt, 4'hF);
    tick();
    chk("sat_stay", bubble_cnt, 4'hF);
    dn_if.ready = 1'b0;
    offer(1'b1, 30'd5);
    tick();
    offer(1'b1, 30'd6);
    tick();
    reset = 1'b0;
    flush = 1'b1;
    tick();
    chk("mid_rst_bubble", bubble_cnt, 0);
    chk("mid_rst_valid", dn_if.valid, 0);
    chk("mid_rst_skid", skid_full, 0);
    chk("mid_rst_up_ready", up_if.ready, 1);
    reset = 1'b1;
    flush = 1'b0;
    offer(1'b0, 30'h0);
    tick();
    chk("post_rst_bubble", bubble_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
